// File: rtl/cmos_pixel_packer.sv
// DVP sensor front end: packs RATIO beats into one pixel in the pclk domain,
// locks to frame start, tracks pixel/line coordinates and flags bad line/frame lengths.
module cmos_pixel_packer #(
  parameter int unsigned IN_W        = 8,
  parameter int unsigned RATIO       = 2,
  parameter int unsigned MSB_FIRST   = 1,
  parameter int unsigned VS_POL      = 1,
  parameter int unsigned SKIP_FRAMES = 0,
  parameter int unsigned H_ACT       = 1280,
  parameter int unsigned V_ACT       = 720,
  parameter int unsigned CNT_W       = 12
) (
  input  logic                  pclk,
  input  logic                  rst_n,
  input  logic                  vs_i,
  input  logic                  de_i,
  input  logic [IN_W-1:0]       pdata_i,
  input  logic                  clr_err_i,
  output logic                  pix_valid_o,
  output logic [IN_W*RATIO-1:0] pix_data_o,
  output logic                  sof_o,
  output logic                  eol_o,
  output logic [CNT_W-1:0]      pix_cnt_o,
  output logic [CNT_W-1:0]      line_cnt_o,
  output logic                  line_err_o,
  output logic                  frame_err_o,
  output logic [1:0]            err_sticky_o,
  output logic                  locked_o
);

  localparam int unsigned PIX_W = IN_W * RATIO;
  localparam int unsigned ACC_W = (RATIO > 1) ? (RATIO - 1) * IN_W : 1;
  localparam int unsigned BC_W  = 2;
  localparam int unsigned SK_W  = 4;
  localparam logic             VS_LVL  = (VS_POL != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] H_CNT   = CNT_W'(H_ACT);
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_ACT - 1);
  localparam logic [CNT_W-1:0] V_CNT   = CNT_W'(V_ACT);
  localparam logic [BC_W-1:0]  BC_LAST = BC_W'(RATIO - 1);
  localparam logic [SK_W-1:0]  SK_LAST = SK_W'(SKIP_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_ACTIVE} state_t;

  state_t            r_state;
  logic              r_vs;
  logic              r_de;
  logic [SK_W-1:0]   r_skip_cnt;
  logic [BC_W-1:0]   r_beat_cnt;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_px;
  logic [CNT_W-1:0]  r_line;
  logic              r_first_frame;
  logic              r_pix_valid;
  logic [PIX_W-1:0]  r_pix_data;
  logic              r_sof;
  logic              r_eol;
  logic [CNT_W-1:0]  r_pix_cnt;
  logic [CNT_W-1:0]  r_line_cnt;
  logic              r_line_err;
  logic              r_frame_err;
  logic [1:0]        r_err_sticky;
  logic              r_locked;

  logic              w_vs_act;
  logic              w_vs_lead;
  logic              w_de_fall;
  logic              w_active;
  logic              w_beat;
  logic              w_last_beat;
  logic              w_line_end;
  logic [PIX_W-1:0]  w_word;
  logic [ACC_W-1:0]  w_acc_next;

  assign w_vs_act    = ~(vs_i ^ VS_LVL);
  assign w_vs_lead   = w_vs_act & ~r_vs;
  assign w_de_fall   = r_de & ~de_i;
  assign w_active    = (r_state == S_ACTIVE);
  assign w_beat      = w_active & de_i & ~w_vs_act;
  assign w_last_beat = (r_beat_cnt == BC_LAST);
  assign w_line_end  = w_active & w_de_fall & ~w_vs_act;

  // Word as it would look with the current beat included; r_acc keeps earlier beats
  if (RATIO == 1) begin : g_r1
    assign w_word     = pdata_i;
    assign w_acc_next = '0;
  end else if (MSB_FIRST != 0) begin : g_msb
    assign w_word     = {r_acc, pdata_i};
    assign w_acc_next = w_word[ACC_W-1:0];
  end else begin : g_lsb
    assign w_word     = {pdata_i, r_acc};
    assign w_acc_next = w_word[PIX_W-1:IN_W];
  end

  assign pix_valid_o  = r_pix_valid;
  assign pix_data_o   = r_pix_data;
  assign sof_o        = r_sof;
  assign eol_o        = r_eol;
  assign pix_cnt_o    = r_pix_cnt;
  assign line_cnt_o   = r_line_cnt;
  assign line_err_o   = r_line_err;
  assign frame_err_o  = r_frame_err;
  assign err_sticky_o = r_err_sticky;
  assign locked_o     = r_locked;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_vs          <= 1'b0;
      r_de          <= 1'b0;
      r_skip_cnt    <= '0;
      r_beat_cnt    <= '0;
      r_acc         <= '0;
      r_px          <= '0;
      r_line        <= '0;
      r_first_frame <= 1'b0;
      r_pix_valid   <= 1'b0;
      r_pix_data    <= '0;
      r_sof         <= 1'b0;
      r_eol         <= 1'b0;
      r_pix_cnt     <= '0;
      r_line_cnt    <= '0;
      r_line_err    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_err_sticky  <= 2'b00;
      r_locked      <= 1'b0;
    end else begin
      r_vs        <= w_vs_act;
      r_de        <= de_i;
      r_pix_valid <= 1'b0;
      r_sof       <= 1'b0;
      r_eol       <= 1'b0;
      r_line_err  <= 1'b0;
      r_frame_err <= 1'b0;
      // Sticky follows the visible pulses, so a clear in a pulse cycle loses
      r_err_sticky <= (r_err_sticky & ~{2{clr_err_i}}) | {r_frame_err, r_line_err};

      case (r_state)
        S_IDLE: begin
          if (w_vs_lead) begin
            r_px       <= '0;
            r_line     <= '0;
            r_beat_cnt <= '0;
            if (SKIP_FRAMES == 0) begin
              r_state       <= S_ACTIVE;
              r_locked      <= 1'b1;
              r_first_frame <= 1'b1;
            end else begin
              r_state    <= S_SKIP;
              r_skip_cnt <= SK_W'(1);
            end
          end
        end

        S_SKIP: begin
          if (w_vs_lead) begin
            if (r_skip_cnt == SK_LAST) begin
              r_state       <= S_ACTIVE;
              r_locked      <= 1'b1;
              r_first_frame <= 1'b1;
              r_px          <= '0;
              r_line        <= '0;
              r_beat_cnt    <= '0;
            end else begin
              r_skip_cnt <= r_skip_cnt + SK_W'(1);
            end
          end
        end

        S_ACTIVE: begin
          if (w_beat) begin
            r_acc <= w_acc_next;
            if (w_last_beat) begin
              r_beat_cnt <= '0;
              // Words past the active width are counted but never emitted
              if (r_px < H_CNT) begin
                r_pix_valid <= 1'b1;
                r_pix_data  <= w_word;
                r_pix_cnt   <= r_px;
                r_line_cnt  <= r_line;
                r_sof       <= (r_px == '0) && (r_line == '0);
                r_eol       <= (r_px == H_LAST);
              end
              if (r_px != CNT_MAX) r_px <= r_px + CNT_W'(1);
            end else begin
              r_beat_cnt <= r_beat_cnt + BC_W'(1);
            end
          end else if (w_line_end) begin
            r_line_err <= (r_beat_cnt != '0) || (r_px != H_CNT);
            r_beat_cnt <= '0;
            r_px       <= '0;
            if (r_line != CNT_MAX) r_line <= r_line + CNT_W'(1);
          end

          if (w_vs_lead) begin
            r_frame_err   <= ~r_first_frame && (r_line != V_CNT);
            r_first_frame <= 1'b0;
            r_line        <= '0;
            r_px          <= '0;
            r_beat_cnt    <= '0;
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmos_pixel_packer.sv
// Bench for cmos_pixel_packer: two configurations driven by one stream, checked
// every cycle against a frame/line/word-level model plus a few literal anchors.
`timescale 1ns/1ps
module tb_cmos_pixel_packer;

  localparam int unsigned IN_W  = 8;
  localparam int unsigned RATIO = 2;
  localparam int unsigned H     = 1280;
  localparam int unsigned V     = 3;
  localparam int unsigned CW    = 12;
  localparam int          CMAX  = 4095;

  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  logic vs = 1'b0;
  logic de = 1'b0;
  logic clr = 1'b0;
  logic [7:0] pdata = 8'h00;
  logic vs_b;
  assign vs_b = ~vs;

  logic        pv   [2];
  logic [15:0] pd   [2];
  logic        sof  [2];
  logic        eol  [2];
  logic [11:0] pcnt [2];
  logic [11:0] lcnt [2];
  logic        lerr [2];
  logic        ferr [2];
  logic [1:0]  stk  [2];
  logic        lck  [2];

  // A: msb-first, active-high VS, no skip.  B: lsb-first, active-low VS, skip 2.
  cmos_pixel_packer #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(1), .VS_POL(1),
    .SKIP_FRAMES(0), .H_ACT(H), .V_ACT(V), .CNT_W(CW)) u_a (
    .pclk(pclk), .rst_n(rst_n), .vs_i(vs), .de_i(de), .pdata_i(pdata),
    .clr_err_i(clr), .pix_valid_o(pv[0]), .pix_data_o(pd[0]), .sof_o(sof[0]),
    .eol_o(eol[0]), .pix_cnt_o(pcnt[0]), .line_cnt_o(lcnt[0]),
    .line_err_o(lerr[0]), .frame_err_o(ferr[0]), .err_sticky_o(stk[0]),
    .locked_o(lck[0]));

  cmos_pixel_packer #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(0), .VS_POL(0),
    .SKIP_FRAMES(2), .H_ACT(H), .V_ACT(V), .CNT_W(CW)) u_b (
    .pclk(pclk), .rst_n(rst_n), .vs_i(vs_b), .de_i(de), .pdata_i(pdata),
    .clr_err_i(clr), .pix_valid_o(pv[1]), .pix_data_o(pd[1]), .sof_o(sof[1]),
    .eol_o(eol[1]), .pix_cnt_o(pcnt[1]), .line_cnt_o(lcnt[1]),
    .line_err_o(lerr[1]), .frame_err_o(ferr[1]), .err_sticky_o(stk[1]),
    .locked_o(lck[1]));

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_pass   = 0;
  int strobes [2] = '{0, 0};
  int lerrs   [2] = '{0, 0};
  int ferrs   [2] = '{0, 0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit cfg_msb  [2] = '{1'b1, 1'b0};
  bit cfg_pol  [2] = '{1'b1, 1'b0};
  int cfg_skip [2] = '{0, 2};

  bit         m_locked [2];
  bit         m_first  [2];
  bit         m_vsr    [2];
  bit         m_der    [2];
  int         m_leads  [2];
  int         m_nb     [2];
  int         m_px     [2];
  int         m_line   [2];
  logic [7:0] m_beats  [2][4];

  logic        e_valid  [2];
  logic [15:0] e_data   [2];
  logic        e_sof    [2];
  logic        e_eol    [2];
  logic [11:0] e_pcnt   [2];
  logic [11:0] e_lcnt   [2];
  logic        e_lerr   [2];
  logic        e_ferr   [2];
  logic [1:0]  e_sticky [2];
  logic        e_locked [2];

  function automatic logic [15:0] pack(input int k);
    logic [15:0] w;
    int slot;
    w = '0;
    for (int i = 0; i < RATIO; i++) begin
      slot = cfg_msb[k] ? (RATIO - 1 - i) : i;
      w = w | (16'(m_beats[k][i]) << (8 * slot));
    end
    return w;
  endfunction

  task automatic model_reset(input int k);
    m_locked[k] = 0; m_first[k] = 0; m_vsr[k] = 0; m_der[k] = 0;
    m_leads[k] = 0; m_nb[k] = 0; m_px[k] = 0; m_line[k] = 0;
    e_valid[k] = 0; e_data[k] = '0; e_sof[k] = 0; e_eol[k] = 0;
    e_pcnt[k] = '0; e_lcnt[k] = '0; e_lerr[k] = 0; e_ferr[k] = 0;
    e_sticky[k] = 2'b00; e_locked[k] = 0;
  endtask

  task automatic model_step(input int k);
    bit pin, va, lead, fall;
    pin  = (k == 0) ? vs : vs_b;
    va   = cfg_pol[k] ? pin : !pin;
    lead = va && !m_vsr[k];
    fall = m_der[k] && !de;
    m_vsr[k] = va;
    m_der[k] = de;
    e_sticky[k] = (clr ? 2'b00 : e_sticky[k]) | {e_ferr[k], e_lerr[k]};
    e_valid[k] = 0; e_sof[k] = 0; e_eol[k] = 0; e_lerr[k] = 0; e_ferr[k] = 0;
    if (!m_locked[k]) begin
      if (lead) begin
        m_leads[k]++;
        if (m_leads[k] > cfg_skip[k]) begin
          m_locked[k] = 1; m_first[k] = 1;
          m_px[k] = 0; m_line[k] = 0; m_nb[k] = 0;
        end
      end
    end else begin
      if (!va && de) begin
        m_beats[k][m_nb[k]] = pdata;
        m_nb[k]++;
        if (m_nb[k] == RATIO) begin
          if (m_px[k] < H) begin
            e_valid[k] = 1;
            e_data[k]  = pack(k);
            e_pcnt[k]  = 12'(m_px[k]);
            e_lcnt[k]  = 12'(m_line[k]);
            e_sof[k]   = (m_px[k] == 0) && (m_line[k] == 0);
            e_eol[k]   = (m_px[k] == H - 1);
          end
          if (m_px[k] < CMAX) m_px[k]++;
          m_nb[k] = 0;
        end
      end else if (!va && fall) begin
        e_lerr[k] = (m_nb[k] != 0) || (m_px[k] != H);
        m_nb[k] = 0;
        m_px[k] = 0;
        if (m_line[k] < CMAX) m_line[k]++;
      end
      if (lead) begin
        e_ferr[k]  = !m_first[k] && (m_line[k] != V);
        m_first[k] = 0;
        m_line[k] = 0; m_px[k] = 0; m_nb[k] = 0;
      end
    end
    e_locked[k] = m_locked[k];
  endtask

  function automatic logic [47:0] act_vec(input int k);
    return {pv[k], pd[k], sof[k], eol[k], pcnt[k], lcnt[k], lerr[k], ferr[k], stk[k], lck[k]};
  endfunction

  function automatic logic [47:0] exp_vec(input int k);
    return {e_valid[k], e_data[k], e_sof[k], e_eol[k], e_pcnt[k], e_lcnt[k],
            e_lerr[k], e_ferr[k], e_sticky[k], e_locked[k]};
  endfunction

  // Per-cycle compare of both instances against the model
  initial begin
    model_reset(0);
    model_reset(1);
    forever begin
      @(posedge pclk);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) model_reset(k);
        else model_step(k);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        check((k == 0) ? "outputs_A" : "outputs_B", 64'(act_vec(k)), 64'(exp_vec(k)));
        if (pv[k] === 1'b1) strobes[k]++;
        if (lerr[k] === 1'b1) lerrs[k]++;
        if (ferr[k] === 1'b1) ferrs[k]++;
      end
    end
  end

  // ---------------- stimulus ----------------
  // Inputs are applied at a negedge; returns at the following negedge
  task automatic drive(input logic v, input logic d, input logic [7:0] p, input logic c);
    vs = v; de = d; pdata = p; clr = c;
    @(negedge pclk);
  endtask

  task automatic send_line(input int n, input bit rnd, input bit lit, input bit exp_sof,
                           input bit hold_de);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, rnd ? 8'($urandom) : 8'(i), 1'b0);
      if (lit && i == 1)
        check("A_first_pixel", 64'({pv[0], pd[0], sof[0]}), 64'({1'b1, 16'h0001, exp_sof}));
      if (lit && i == 2559)
        check("A_eol_pixel", 64'({pv[0], pd[0], eol[0]}), 64'({1'b1, 16'hFEFF, 1'b1}));
    end
    if (!hold_de) repeat (2 + $urandom_range(0, 3)) drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic vsync(input int len, input int de_hold);
    for (int i = 0; i < len; i++) drive(1'b1, (i < de_hold) ? 1'b1 : 1'b0, 8'($urandom), 1'b0);
    repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    int sa, sb, la;
    int lens [5] = '{2560, 2559, 2561, 2566, 37};
    @(negedge pclk);
    repeat (4) drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("reset_A", 64'(act_vec(0)), 64'h0);
    check("reset_B", 64'(act_vec(1)), 64'h0);
    rst_n = 1'b1;
    repeat (3) drive(1'b0, 1'b1, 8'h55, 1'b0);
    check("idle_no_strobe_A", 64'(strobes[0]), 64'd0);

    // Frame 1: A locks, B skips
    vsync(4, 0);
    check("A_locked_lead1", 64'(lck[0]), 64'd1);
    sa = strobes[0]; sb = strobes[1];
    send_line(2560, 1'b0, 1'b1, 1'b1, 1'b0);
    check("A_strobes_line", 64'(strobes[0] - sa), 64'd1280);
    send_line(2560, 1'b0, 1'b1, 1'b0, 1'b0);
    send_line(2560, 1'b0, 1'b1, 1'b0, 1'b0);
    check("B_skip_no_strobes", 64'(strobes[1] - sb), 64'd0);

    // Frame 2: one short line
    vsync(4, 0);
    send_line(2560, 1'b1, 1'b0, 1'b0, 1'b0);
    sa = strobes[0]; la = lerrs[0];
    send_line(2559, 1'b0, 1'b0, 1'b0, 1'b0);
    check("A_short_line_strobes", 64'(strobes[0] - sa), 64'd1279);
    check("A_line_err_pulses", 64'(lerrs[0] - la), 64'd1);
    check("A_sticky_line", 64'(stk[0]), 64'b01);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    check("A_sticky_cleared", 64'(stk[0]), 64'b00);
    send_line(2560, 1'b1, 1'b0, 1'b0, 1'b0);
    check("B_unlocked_before_lead3", 64'(lck[1]), 64'd0);

    // Frame 3: B locks; byte order anchors; only V-1 lines
    vsync(4, 0);
    check("B_locked_lead3", 64'(lck[1]), 64'd1);
    drive(1'b0, 1'b1, 8'hAB, 1'b0);
    drive(1'b0, 1'b1, 8'hCD, 1'b0);
    check("A_msb_first", 64'({pv[0], pd[0]}), 64'({1'b1, 16'hABCD}));
    check("B_lsb_first", 64'({pv[1], pd[1]}), 64'({1'b1, 16'hCDAB}));
    send_line(2558, 1'b1, 1'b0, 1'b0, 1'b0);
    send_line(2560, 1'b1, 1'b0, 1'b0, 1'b0);

    // Short frame ends; clear requested in the pulse cycle
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    check("A_frame_err_pulse", 64'(ferr[0]), 64'd1);
    check("B_first_frame_unchecked", 64'(ferr[1]), 64'd0);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    check("A_sticky_set_wins", 64'(stk[0]), 64'b10);
    vsync(2, 0);

    // Frame 4: random line lengths, last line left open into VS
    for (int l = 0; l < 3; l++)
      send_line(lens[$urandom_range(0, 4)], 1'b1, 1'b0, 1'b0, 1'b0);
    send_line(500, 1'b1, 1'b0, 1'b0, 1'b1);
    vsync(5, 2);

    // Frame 5: overlong line saturates px; then reset mid-line
    sa = strobes[0]; sb = strobes[1];
    send_line(8200, 1'b1, 1'b0, 1'b0, 1'b0);
    check("A_overlong_strobes", 64'(strobes[0] - sa), 64'd1280);
    check("B_overlong_strobes", 64'(strobes[1] - sb), 64'd1280);
    send_line(301, 1'b1, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("A_async_reset", 64'(act_vec(0)), 64'h0);
    check("B_async_reset", 64'(act_vec(1)), 64'h0);
    repeat (3) drive(1'b0, 1'b1, 8'($urandom), 1'b0);
    rst_n = 1'b1;
    sa = strobes[0]; sb = strobes[1];
    for (int i = 0; i < 60; i++) drive(1'b0, 1'($urandom), 8'($urandom), 1'b0);
    check("A_no_strobe_after_reset", 64'(strobes[0] - sa), 64'd0);
    check("B_no_strobe_after_reset", 64'(strobes[1] - sb), 64'd0);
    check("A_unlocked_after_reset", 64'(lck[0]), 64'd0);

    // Frame 6: A relocks immediately, B is skipping again
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    vsync(3, 0);
    sb = strobes[1];
    send_line(2560, 1'b0, 1'b1, 1'b1, 1'b0);
    check("B_skip_after_reset", 64'(strobes[1] - sb), 64'd0);
    repeat (4) drive(1'b0, 1'b0, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
